audio_frame_scheduler: RTL and testbench
========================================

Name: audio_frame_scheduler

Overview:
Sits between the APU sample producer and SoundDriver. It buffers mono 16-bit samples in a small FIFO. Once codec configuration reports done, it paces output at the codec frame rate (32 kHz): each frame it pops one sample, applies mute and attenuation, and issues a write_left/write_right pulse pair to SoundDriver. On underrun it repeats the last sample and counts the event.

Parameters:
CLK_HZ, 24000000, system clock frequency
FS_HZ, 32000, output frame rate; FRAME_DIV = CLK_HZ/FS_HZ (750 at defaults)
SAMPLE_W, 16, sample width
FIFO_DEPTH, 8, input FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock, 24 MHz
reset_n  in  1  synchronous, active-low reset
cfg_done  in  1  codec configuration complete (from WM8731_Config.done)
in_valid  in  1  producer sample valid
in_sample  in  SAMPLE_W  signed producer sample
in_ready  out  1  FIFO not full
mute  in  1  force zero output
atten  in  3  arithmetic right-shift amount, 0..7
write_data  out  SAMPLE_W  sample to SoundDriver
write_left  out  1  one-cycle load strobe, left buffer
write_right  out  1  one-cycle load strobe, right buffer
fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy
underrun_cnt  out  16  saturating count of empty-FIFO frames

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FIFO empty; fifo_level=0; in_ready=1.
  - write_left=0, write_right=0, write_data=0.
  - underrun_cnt=0; held sample=0; frame counter=0; state=WAIT_CFG.
  - Applies mid-frame; any pending strobe is cancelled.
- Push: occurs when in_valid && in_ready.
  - in_ready is combinational: (fifo_level != FIFO_DEPTH).
  - A push while full cannot happen, because in_ready=0.
- FIFO: first-word fall-through. A push and pop in the same cycle are both honoured and fifo_level is unchanged. A push to an empty FIFO is poppable on the next cycle.
- States:
  - WAIT_CFG: frame counter held at 0. FIFO accepts pushes until full. Go to IDLE when cfg_done=1. cfg_done is sticky internally; later deassertion is ignored until reset.
  - IDLE: frame counter increments and wraps at FRAME_DIV-1. The tick occurs on the cycle where the counter equals FRAME_DIV-1 (cycle T). On the tick:
    - FIFO non-empty: pop the head into the held sample.
    - FIFO empty: keep the held sample and increment underrun_cnt, saturating at 0xFFFF.
    - Then go to LOAD.
  - LOAD (T+1): register write_data = mute ? 0 : (held >>> atten), a sign-preserving shift. Go to WR_L.
  - WR_L (T+2): write_left=1 for exactly this cycle. Go to WR_R.
  - WR_R (T+3): write_right=1 for exactly this cycle, write_data unchanged. Go to IDLE.
- Frame counter keeps running through LOAD/WR_L/WR_R, so the tick period is exactly FRAME_DIV cycles.
- write_left and write_right are never high together. Each strobe occurs once per frame.
- write_data is stable from T+2 through the next frame's T+1.
- mute and atten are sampled only in LOAD; changes mid-frame take effect next frame.
- FRAME_DIV must be at least 4 (elaboration assertion).

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W
  - frame-divider function (CLK_HZ/FS_HZ)
  - state encoding WAIT_CFG/IDLE/LOAD/WR_L/WR_R
  - UNDERRUN_MAX constant
- Sub-module audio_sample_fifo (parameterised by SAMPLE_W and FIFO_DEPTH): push/pop/level, first-word fall-through.
- Scheduler FSM, frame counter and scaling logic stay in the top module.

Test Plan:
1. Reset, cfg_done=0, push 10 samples -> in_ready drops after the 8th push, fifo_level=8, no write strobes for 2000 cycles.
2. Raise cfg_done with FIFO holding 0x1234, atten=0, mute=0 -> first tick at cycle 749 after IDLE entry. write_left pulses at T+2 and write_right at T+3, both with write_data=0x1234. Strobe pairs repeat every 750 cycles.
3. Sample 0x8000 with atten=3 -> write_data=0xF000. Same sample with mute=1 -> write_data=0x0000.
4. Empty FIFO at 3 consecutive ticks after last sample 0x0ABC -> three frames output 0x0ABC and underrun_cnt=3. Force the count to 0xFFFF and underrun again -> count stays 0xFFFF.
5. Push on the exact tick cycle with FIFO level=1 -> the pop and push both succeed, level stays 1, and the popped value is the older sample.
6. Assert reset_n=0 in the WR_L cycle -> write_left drops next edge, no write_right, all outputs return to reset values, state=WAIT_CFG.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants, state encoding and frame-divider helper for the audio
// frame scheduler and its sample FIFO.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT_CFG = 3'd0;
    localparam state_t ST_IDLE     = 3'd1;
    localparam state_t ST_LOAD     = 3'd2;
    localparam state_t ST_WR_L     = 3'd3;
    localparam state_t ST_WR_R     = 3'd4;

    function automatic int frame_div(input int clk_hz, input int fs_hz);
        return clk_hz / fs_hz;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// First-word fall-through sample FIFO: the head entry is always visible on
// rdata_o, and a simultaneous push and pop leaves the level unchanged.
module audio_sample_fifo #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push_i,
    input  logic [SAMPLE_W-1:0]           wdata_i,
    input  logic                          pop_i,
    output logic [SAMPLE_W-1:0]           rdata_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                do_push, do_pop;

    assign full_o  = (level_q == LW'(FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap for free because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (do_pop && !do_push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/audio_frame_scheduler.sv
// Paces buffered mono samples out at the codec frame rate, scaling each one
// and issuing a left/right load strobe pair to the sound driver per frame.
module audio_frame_scheduler #(
    parameter int CLK_HZ     = 24000000,
    parameter int FS_HZ      = 32000,
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cfg_done,
    input  logic                          in_valid,
    input  logic [SAMPLE_W-1:0]           in_sample,
    output logic                          in_ready,
    input  logic                          mute,
    input  logic [2:0]                    atten,
    output logic [SAMPLE_W-1:0]           write_data,
    output logic                          write_left,
    output logic                          write_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_cnt
);

    import audio_pkg::*;

    localparam int FRAME_DIV = frame_div(CLK_HZ, FS_HZ);
    localparam int CW        = $clog2(FRAME_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    if (FRAME_DIV < 4) begin : g_div_check
        $error("FRAME_DIV must be at least 4");
    end

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] held_q, held_d;
    logic signed [SAMPLE_W-1:0] scaled;
    logic [SAMPLE_W-1:0]        wdata_q, wdata_d;
    logic [15:0]                underrun_q, underrun_d;
    logic [SAMPLE_W-1:0]        fifo_rdata;
    logic                       fifo_full, fifo_empty;
    logic                       tick, fifo_pop;

    audio_sample_fifo #(
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (in_valid),
        .wdata_i (in_sample),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready = !fifo_full;

    // The strobe states are only ever reached from IDLE on a tick, so the
    // tick can be qualified by IDLE alone without losing any frame.
    assign tick     = (state_q == ST_IDLE) && (cnt_q == CNT_LAST);
    assign fifo_pop = tick && !fifo_empty;
    assign scaled   = held_q >>> atten;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        held_d     = held_q;
        wdata_d    = wdata_q;
        underrun_d = underrun_q;

        if (state_q != ST_WAIT_CFG) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

        case (state_q)
            ST_WAIT_CFG: if (cfg_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (tick) begin
                    if (!fifo_empty)                     held_d     = fifo_rdata;
                    else if (underrun_q != UNDERRUN_MAX) underrun_d = underrun_q + 16'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wdata_d = mute ? '0 : scaled;
                state_d = ST_WR_L;
            end
            ST_WR_L: state_d = ST_WR_R;
            ST_WR_R: state_d = ST_IDLE;
            default: state_d = ST_WAIT_CFG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_WAIT_CFG;
            cnt_q      <= '0;
            held_q     <= '0;
            wdata_q    <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            wdata_q    <= wdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign write_data   = wdata_q;
    assign write_left   = (state_q == ST_WR_L);
    assign write_right  = (state_q == ST_WR_R);
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Scenario bench for audio_frame_scheduler: a queue of pushed samples models
// the FIFO and is popped at every observed write_left strobe.
module tb_audio_frame_scheduler;

    localparam int SW    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset_n, cfg_done, in_valid, mute;
    logic [SW-1:0] in_sample;
    logic [2:0]    atten;
    logic          in_ready, write_left, write_right;
    logic [SW-1:0] write_data;
    logic [LW-1:0] fifo_level;
    logic [15:0]   underrun_cnt;

    int total = 0;
    int bad   = 0;
    int overlap = 0;

    logic [SW-1:0] sb_q [$];
    logic [SW-1:0] held_m = '0;
    logic [15:0]   under_m = '0;

    always #5 clk = ~clk;

    audio_frame_scheduler #(
        .CLK_HZ     (24000000),
        .FS_HZ      (32000),
        .SAMPLE_W   (SW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_done     (cfg_done),
        .in_valid     (in_valid),
        .in_sample    (in_sample),
        .in_ready     (in_ready),
        .mute         (mute),
        .atten        (atten),
        .write_data   (write_data),
        .write_left   (write_left),
        .write_right  (write_right),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt)
    );

    // Model of one frame tick: pop the oldest pushed sample or hold and count.
    function automatic logic [SW-1:0] model_tick();
        if (sb_q.size() > 0) held_m = sb_q.pop_front();
        else if (under_m != 16'hFFFF) under_m = under_m + 16'd1;
        return held_m;
    endfunction

    task automatic push(input logic [SW-1:0] s);
        in_valid  = 1'b1;
        in_sample = s;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_left(input int max, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < max) begin
            @(negedge clk);
            cyc++;
            seen = write_left;
            if (write_left && write_right) overlap++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cfg_done = 1'b0; in_valid = 1'b0; in_sample = '0;
        mute = 1'b0; atten = 3'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        total++; if ({write_left, write_right} !== 2'b00) begin bad++; $display("FAIL rst_strobes: got %b want 00", {write_left, write_right}); end
        total++; if (write_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", write_data); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL rst_underrun: got %0d want 0", underrun_cnt); end
    endtask

    task automatic test_fill_wait_cfg();
        logic [SW-1:0] vals [10];
        logic          exp_rdy;
        int            strobes;
        vals = '{16'h1234, 16'h5678, 16'h8000, 16'h8000, 16'h7FFF,
                 16'h0001, 16'hFFFF, 16'h0ABC, 16'hDEAD, 16'hBEEF};
        for (int i = 0; i < 10; i++) begin
            exp_rdy = (sb_q.size() != DEPTH);
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL fill_ready[%0d]: got %b want %b", i, in_ready, exp_rdy); end
            push(vals[i]);
            if (exp_rdy) sb_q.push_back(vals[i]);
        end
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL fill_level: got %0d want 8", fifo_level); end
        strobes = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (write_left || write_right) strobes++;
        end
        total++; if (strobes !== 0) begin bad++; $display("FAIL wait_cfg_strobes: got %0d want 0", strobes); end
    endtask

    task automatic test_first_frames();
        int            cyc;
        bit            seen;
        logic [SW-1:0] exp;
        atten = 3'd0; mute = 1'b0;
        cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        wait_left(800, cyc, seen);
        total++; if (!seen || (cyc + 1) !== 752) begin bad++; $display("FAIL first_tick: got %0d cycles (seen=%b) want 752", cyc + 1, seen); end
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                wait_left(800, cyc, seen);
                total++; if (!seen || cyc !== 749) begin bad++; $display("FAIL frame_period: got %0d (seen=%b) want 749", cyc, seen); end
            end
            exp = model_tick();
            total++; if (write_data !== exp) begin bad++; $display("FAIL frame%0d_left_data: got %h want %h", f, write_data, exp); end
            @(negedge clk);
            total++; if ({write_left, write_right} !== 2'b01) begin bad++; $display("FAIL frame%0d_right: got %b want 01", f, {write_left, write_right}); end
            total++; if (write_data !== exp) begin bad++; $display("FAIL frame%0d_right_data: got %h want %h", f, write_data, exp); end
        end
    endtask

    task automatic test_scaling();
        logic [2:0]    at_t  [5];
        logic          mu_t  [5];
        logic [SW-1:0] exp_t [5];
        int            cyc;
        bit            seen;
        at_t  = '{3'd3, 3'd0, 3'd7, 3'd0, 3'd2};
        mu_t  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_t = '{16'hF000, 16'h0000, 16'h00FF, 16'h0001, 16'hFFFF};
        for (int i = 0; i < 5; i++) begin
            atten = at_t[i]; mute = mu_t[i];
            wait_left(800, cyc, seen);
            void'(model_tick());
            total++; if (!seen || write_data !== exp_t[i]) begin bad++; $display("FAIL scale[%0d]: got %h (seen=%b) want %h", i, write_data, seen, exp_t[i]); end
            @(negedge clk);
            total++; if (!write_right || write_data !== exp_t[i]) begin bad++; $display("FAIL scale_right[%0d]: got %h r=%b want %h", i, write_data, write_right, exp_t[i]); end
        end
        atten = 3'd0; mute = 1'b0;
    endtask

    task automatic test_underrun();
        int            cyc;
        bit            seen;
        logic [SW-1:0] exp;
        for (int f = 0; f < 4; f++) begin
            wait_left(800, cyc, seen);
            exp = model_tick();
            total++; if (!seen || write_data !== exp) begin bad++; $display("FAIL underrun_data[%0d]: got %h (seen=%b) want %h", f, write_data, seen, exp); end
            @(negedge clk);
        end
        total++; if (write_data !== 16'h0ABC) begin bad++; $display("FAIL underrun_hold: got %h want 0abc", write_data); end
        total++; if (underrun_cnt !== 16'd3) begin bad++; $display("FAIL underrun_cnt: got %0d want 3", underrun_cnt); end
        force dut.underrun_q = 16'hFFFE;
        @(negedge clk);
        release dut.underrun_q;
        under_m = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            wait_left(800, cyc, seen);
            void'(model_tick());
            total++; if (!seen || underrun_cnt !== under_m) begin bad++; $display("FAIL underrun_sat[%0d]: got %h (seen=%b) want %h", f, underrun_cnt, seen, under_m); end
            @(negedge clk);
        end
        total++; if (underrun_cnt !== 16'hFFFF) begin bad++; $display("FAIL underrun_max: got %h want ffff", underrun_cnt); end
    endtask

    task automatic test_push_on_tick();
        int            cyc;
        bit            seen;
        logic [SW-1:0] exp;
        // Entered in the write_right cycle; the next tick is 747 cycles ahead.
        push(16'h1111);
        sb_q.push_back(16'h1111);
        repeat (746) @(negedge clk);
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL tick_pre_level: got %0d want 1", fifo_level); end
        push(16'h2222);
        sb_q.push_back(16'h2222);
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL tick_post_level: got %0d want 1", fifo_level); end
        @(negedge clk);
        exp = model_tick();
        total++; if (!write_left || write_data !== exp) begin bad++; $display("FAIL tick_pop_old: got %h l=%b want %h", write_data, write_left, exp); end
        @(negedge clk);
        wait_left(800, cyc, seen);
        exp = model_tick();
        total++; if (!seen || write_data !== exp) begin bad++; $display("FAIL tick_pop_new: got %h (seen=%b) want %h", write_data, seen, exp); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int            cyc;
        bit            seen;
        int            strobes;
        logic [SW-1:0] exp;
        push(16'h3333); sb_q.push_back(16'h3333);
        push(16'h4444); sb_q.push_back(16'h4444);
        wait_left(800, cyc, seen);
        exp = model_tick();
        total++; if (!seen || write_data !== exp) begin bad++; $display("FAIL prerst_data: got %h (seen=%b) want %h", write_data, seen, exp); end
        reset_n = 1'b0;
        @(negedge clk);
        total++; if ({write_left, write_right} !== 2'b00) begin bad++; $display("FAIL midrst_strobes: got %b want 00", {write_left, write_right}); end
        total++; if (write_data !== 16'h0000) begin bad++; $display("FAIL midrst_data: got %h want 0000", write_data); end
        total++; if (fifo_level !== 4'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_fifo: got level=%0d ready=%b want 0/1", fifo_level, in_ready); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL midrst_underrun: got %h want 0", underrun_cnt); end
        sb_q.delete(); held_m = '0; under_m = '0;
        strobes = 0;
        repeat (2) begin @(negedge clk); if (write_left || write_right) strobes++; end
        reset_n = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (write_left || write_right) strobes++;
        end
        total++; if (strobes !== 0) begin bad++; $display("FAIL postrst_strobes: got %0d want 0", strobes); end
        cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        wait_left(800, cyc, seen);
        exp = model_tick();
        total++; if (!seen || (cyc + 1) !== 752) begin bad++; $display("FAIL postrst_tick: got %0d (seen=%b) want 752", cyc + 1, seen); end
        total++; if (write_data !== exp || underrun_cnt !== under_m) begin bad++; $display("FAIL postrst_held: got %h/%0d want %h/%0d", write_data, underrun_cnt, exp, under_m); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill_wait_cfg();
        test_first_frames();
        test_scaling();
        test_underrun();
        test_push_on_tick();
        test_reset_mid_frame();
        total++; if (overlap !== 0) begin bad++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
